axis_mt19937_rng: RTL and testbench

//  MT19937 32-bit pseudo-random generator with an AXI4-Stream master output.
//  - Holds the 624-word generator state internally and seeds it from a 32-bit value.
//  - Emits tempered words in standard reference order.
//  - Used as a bit-exact random source feeding stream consumers.

---
 rtl/mt19937_pkg.sv | 51 +++++
 rtl/axis_mt19937_rng_if.sv | 22 ++
 rtl/mt19937_state_ram.sv | 22 ++
 rtl/axis_mt19937_rng.sv | 149 ++++++++++++++
 tb/tb_axis_mt19937_rng.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mt19937_pkg.sv
// MT19937 constants, state encoding and word-level helpers
// shared by the generator top, its state RAM and its stream interface.
package mt19937_pkg;

  localparam int N = 624;
  localparam int M = 397;
  localparam int AW = 10;

  typedef logic [31:0]   word_t;
  typedef logic [AW-1:0] addr_t;

  localparam word_t MATRIX_A     = 32'h9908b0df;
  localparam word_t UPPER_MASK   = 32'h80000000;
  localparam word_t LOWER_MASK   = 32'h7fffffff;
  localparam word_t TEMPER_B     = 32'h9d2c5680;
  localparam word_t TEMPER_C     = 32'hefc60000;
  localparam word_t INIT_MULT    = 32'd1812433253;
  localparam word_t DEFAULT_SEED = 32'd5489;

  localparam addr_t LAST_IDX = addr_t'(N - 1);

  typedef enum logic [1:0] {
    INIT,
    SEED,
    RUN
  } state_t;

  function automatic word_t temper(input word_t x);
    word_t t;
    t = x;
    t ^= t >> 11;
    t ^= (t << 7) & TEMPER_B;
    t ^= (t << 15) & TEMPER_C;
    t ^= t >> 18;
    return t;
  endfunction

  function automatic word_t seed_step(input word_t p,
                                      input addr_t i);
    return INIT_MULT * (p ^ (p >> 30)) + 32'(i);
  endfunction

  function automatic word_t twist(input word_t cur,
                                  input word_t nxt,
                                  input word_t far);
    word_t y;
    y = (cur & UPPER_MASK) | (nxt & LOWER_MASK);
    return far ^ (y >> 1) ^ (y[0] ? MATRIX_A : '0);
  endfunction

endpackage

// File: rtl/axis_mt19937_rng_if.sv
// AXI4-Stream word channel carrying tempered MT19937 output.
// master drives data/valid, slave returns ready.
interface axis_mt19937_rng_if;
  import mt19937_pkg::*;

  word_t tdata;
  logic  tvalid;
  logic  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/mt19937_state_ram.sv
// 624x32 generator state store: one synchronous write port,
// one synchronous read port whose output holds while re=0.
module mt19937_state_ram
  import mt19937_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  word_t wdata,
  input  logic  re,
  input  addr_t raddr,
  output word_t rdata
);

  word_t mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_mt19937_rng.sv
// MT19937 generator: seed FSM, per-word twist, tempering and
// an AXI4-Stream output register sustaining one word per clock.
module axis_mt19937_rng
  import mt19937_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  axis_mt19937_rng_if.master         output_axis,
  input  word_t                      seed_val,
  input  logic                       seed_start,
  output logic                       busy
);

  state_t state, state_nx;

  word_t seed_q, prev_q, cur_q, tdata_q;
  addr_t sidx_q, idx_q;
  logic  tvalid_q, busy_q;

  logic  we, re;
  addr_t waddr, raddr_a, raddr_b;
  word_t wdata, rd_a, rd_b;
  word_t seed_word, gen_word;
  addr_t idx_p2, idx_pm1;
  logic  accept, advance;

  // Two copies of the state: one streams mt[i+1], the other
  // mt[i+M]; mt[i] itself is carried over from the previous rd_a.
  mt19937_state_ram u_ram_a (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr_a),
    .rdata (rd_a)
  );

  mt19937_state_ram u_ram_b (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr_b),
    .rdata (rd_b)
  );

  assign seed_word = seed_step(prev_q, sidx_q);
  assign gen_word  = twist(cur_q, rd_a, rd_b);
  assign accept    = seed_start && !busy_q;
  assign advance   = (state == RUN) &&
                     (!tvalid_q || output_axis.tready);

  assign idx_p2  = (idx_q >= addr_t'(N - 2)) ?
                   idx_q - addr_t'(N - 2) : idx_q + addr_t'(2);
  assign idx_pm1 = (idx_q >= addr_t'(N - M - 1)) ?
                   idx_q - addr_t'(N - M - 1) :
                   idx_q + addr_t'(M + 1);

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    we       = 1'b0;
    re       = 1'b0;
    waddr    = idx_q;
    wdata    = gen_word;
    raddr_a  = idx_p2;
    raddr_b  = idx_pm1;
    unique case (state)
      INIT: begin
        we       = 1'b1;
        waddr    = '0;
        wdata    = seed_q;
        state_nx = SEED;
      end
      SEED: begin
        we    = 1'b1;
        waddr = sidx_q;
        wdata = seed_word;
        if (sidx_q == LAST_IDX) begin
          re       = 1'b1;
          raddr_a  = addr_t'(1);
          raddr_b  = addr_t'(M);
          state_nx = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          state_nx = INIT;
        end else if (advance) begin
          we = 1'b1;
          re = 1'b1;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q   <= DEFAULT_SEED;
      prev_q   <= '0;
      cur_q    <= '0;
      sidx_q   <= '0;
      idx_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      unique case (state)
        INIT: begin
          prev_q <= seed_q;
          cur_q  <= seed_q;
          sidx_q <= addr_t'(1);
          idx_q  <= '0;
        end
        SEED: begin
          prev_q <= seed_word;
          sidx_q <= sidx_q + addr_t'(1);
        end
        RUN: begin
          if (accept) begin
            seed_q   <= seed_val;
            busy_q   <= 1'b1;
            tvalid_q <= 1'b0;
          end else if (advance) begin
            cur_q    <= rd_a;
            tdata_q  <= temper(gen_word);
            tvalid_q <= 1'b1;
            busy_q   <= 1'b0;
            idx_q    <= (idx_q == LAST_IDX) ?
                        '0 : idx_q + addr_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign output_axis.tdata  = tdata_q;
  assign output_axis.tvalid = tvalid_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_axis_mt19937_rng.sv
// Directed-vector bench for axis_mt19937_rng with a
// block-regenerating MT19937 reference for whole-stream checks.
module tb_axis_mt19937_rng;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seed_val = '0;
  logic        seed_start = 1'b0;
  logic        busy;

  int tests = 0;
  int fails = 0;

  axis_mt19937_rng_if axis ();

  axis_mt19937_rng dut (
    .clk         (clk),
    .rst         (rst),
    .output_axis (axis),
    .seed_val    (seed_val),
    .seed_start  (seed_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mt_m [624];
  int          mti;

  task automatic m_seed(input logic [31:0] s);
    mt_m[0] = s;
    for (int i = 1; i < 624; i++)
      mt_m[i] = 32'd1812433253 *
                (mt_m[i-1] ^ (mt_m[i-1] >> 30)) + 32'(i);
    mti = 624;
  endtask

  task automatic m_next(output logic [31:0] r);
    logic [31:0] y;
    if (mti >= 624) begin
      for (int k = 0; k < 624; k++) begin
        y = (mt_m[k] & 32'h80000000) |
            (mt_m[(k + 1) % 624] & 32'h7fffffff);
        mt_m[k] = mt_m[(k + 397) % 624] ^ (y >> 1) ^
                  (y[0] ? 32'h9908b0df : 32'h0);
      end
      mti = 0;
    end
    y = mt_m[mti];
    mti++;
    y ^= y >> 11;
    y ^= (y << 7) & 32'h9d2c5680;
    y ^= (y << 15) & 32'hefc60000;
    y ^= y >> 18;
    r = y;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic pop(output logic [31:0] w, output int waited);
    axis.tready = 1'b1;
    w = '0;
    waited = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (axis.tvalid === 1'b1) begin
        w = axis.tdata;
        waited = k;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL pop_timeout: got no tvalid, expected tvalid within 2000 cycles");
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    tests++;
    fails++;
    $display("FAIL idle_timeout: got busy=1, expected busy=0 within 2000 cycles");
  endtask

  task automatic reseed(input logic [31:0] s);
    wait_idle();
    seed_val   = s;
    seed_start = 1'b1;
    @(negedge clk);
    seed_start = 1'b0;
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          by_rst;
    logic [31:0] seed;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] w, mw, last, held;
    int waited, gaps, mism, bc, acc, st_err, sq_err;
    bit stall, early_valid;

    vecs[0] = '{1'b1, 32'd5489, 1,     32'd3499211612};
    vecs[1] = '{1'b1, 32'd5489, 2,     32'd581869302};
    vecs[2] = '{1'b1, 32'd5489, 3,     32'd3890346734};
    vecs[3] = '{1'b0, 32'd1,    1,     32'd1791095845};
    vecs[4] = '{1'b0, 32'd1,    2,     32'd4282876139};
    vecs[5] = '{1'b1, 32'd5489, 10000, 32'd4123659995};

    axis.tready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(axis.tvalid), 0);
    check("rst_busy",   32'(busy), 1);
    check("rst_tdata",  axis.tdata, 0);
    rst = 1'b0;

    bc = 0;
    early_valid = 1'b0;
    @(negedge clk);
    while (busy === 1'b1 && bc < 2000) begin
      if (axis.tvalid !== 1'b0) early_valid = 1'b1;
      bc++;
      @(negedge clk);
    end
    check("busy_bounded",   32'(bc <= 1024), 1);
    check("valid_in_busy",  32'(early_valid), 0);
    check("valid_at_ready", 32'(axis.tvalid), 1);

    foreach (vecs[i]) begin
      if (vecs[i].by_rst) hard_reset();
      else reseed(vecs[i].seed);
      m_seed(vecs[i].seed);
      gaps = 0;
      mism = 0;
      last = '0;
      for (int k = 1; k <= vecs[i].n; k++) begin
        pop(w, waited);
        if (waited < 0) break;
        if (k > 1 && waited != 0) gaps++;
        m_next(mw);
        if (w !== mw) mism++;
        last = w;
      end
      check($sformatf("vec%0d_word", i), last, vecs[i].exp);
      check($sformatf("vec%0d_gaps", i), gaps, 0);
      check($sformatf("vec%0d_model", i), mism, 0);
    end

    hard_reset();
    m_seed(32'd5489);
    stall = 1'b0;
    held = '0;
    acc = 0;
    st_err = 0;
    sq_err = 0;
    for (int c = 0; c < 20000 && acc < 1500; c++) begin
      @(negedge clk);
      axis.tready = 1'($urandom_range(0, 1));
      if (stall && (axis.tvalid !== 1'b1 || axis.tdata !== held))
        st_err++;
      if (axis.tvalid === 1'b1 && axis.tready) begin
        m_next(mw);
        if (axis.tdata !== mw) sq_err++;
        acc++;
      end
      stall = (axis.tvalid === 1'b1) && !axis.tready;
      held = axis.tdata;
    end
    check("thr_count",  acc, 1500);
    check("thr_stable", st_err, 0);
    check("thr_seq",    sq_err, 0);

    reseed(32'd1);
    for (int k = 0; k < 700; k++) pop(w, waited);
    seed_val   = 32'd5489;
    seed_start = 1'b1;
    @(negedge clk);
    seed_start = 1'b0;
    check("reseed_busy",   32'(busy), 1);
    check("reseed_tvalid", 32'(axis.tvalid), 0);
    pop(w, waited);
    check("reseed_w1", w, 32'd3499211612);
    pop(w, waited);
    check("reseed_w2", w, 32'd581869302);

    hard_reset();
    repeat (10) @(negedge clk);
    seed_val   = 32'd1;
    seed_start = 1'b1;
    @(negedge clk);
    seed_start = 1'b0;
    pop(w, waited);
    check("busy_seed_w1", w, 32'd3499211612);
    pop(w, waited);
    check("busy_seed_w2", w, 32'd581869302);

    reseed(32'd1);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",   32'(busy), 1);
    check("midrst_tvalid", 32'(axis.tvalid), 0);
    rst = 1'b0;
    pop(w, waited);
    check("midrst_w1", w, 32'd3499211612);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
